// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared constants and state encoding for the 1:4 round-robin demux dispatcher.
package demux_rr_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int CW   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ARB  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_rr_dispatcher_if.sv
// Handshake, flow-control and status bundle between upstream/downstream and the dispatcher.
interface demux_rr_dispatcher_if #(
  parameter int DW = 8
);
  import demux_rr_pkg::*;

  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  credit_ret;
  logic [SELW-1:0] sel;
  logic [DW-1:0]   out_data;
  logic [NCH-1:0]  out_valid;
  logic            busy;
  logic            err_stall;

  modport master (
    output in_valid, in_data, ch_en, credit_ret,
    input  in_ready, sel, out_data, out_valid, busy, err_stall
  );

  modport slave (
    input  in_valid, in_data, ch_en, credit_ret,
    output in_ready, sel, out_data, out_valid, busy, err_stall
  );

endinterface

// File: rtl/demux_rr_dispatcher_rr_pick4.sv
// Rotating-priority picker: first eligible channel at or after ptr, wrapping mod 4.
module rr_pick4
  import demux_rr_pkg::*;
(
  input  logic [NCH-1:0]  eligible,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] j;

  // Scan from farthest to nearest offset so the nearest eligible channel wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = ptr + SELW'(k);
      if (eligible[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Single-word buffered dispatcher: round-robin over enabled, credited channels with stall watchdog.
module demux_rr_dispatcher
  import demux_rr_pkg::*;
#(
  parameter int DW        = 8,
  parameter int CREDITS   = 4,
  parameter int STALL_LIM = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_rr_dispatcher_if.slave  bus
);

  state_t          state_q, state_d;
  logic            vld_p0;
  logic [DW-1:0]   hold_p0;
  logic [SELW-1:0] ptr_q;
  logic [7:0]      stall_q;
  logic            err_q;
  logic [CW-1:0]   credit_q [NCH];
  logic [NCH-1:0]  eligible;
  logic            found;
  logic [SELW-1:0] idx;
  logic            load, dispatch, blocked;
  logic [NCH-1:0]  out_valid_q;
  logic [SELW-1:0] sel_q;
  logic [DW-1:0]   out_data_q;

  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c,
                                                 input logic ret,
                                                 input logic take);
    case ({ret, take})
      2'b10:   return (c >= CW'(CREDITS)) ? CW'(CREDITS) : c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  function automatic logic [7:0] stall_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  assign vld_p0 = (state_q == ARB);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCH; i++)
      eligible[i] = bus.ch_en[i] && (credit_q[i] != '0);
  end

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (found),
    .idx      (idx)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    dispatch = 1'b0;
    blocked  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        if (found) begin
          dispatch = 1'b1;
          state_d  = IDLE;
        end else begin
          blocked = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: holding register, data only
  always_ff @(posedge clk) begin
    if (load) hold_p0 <= bus.in_data;
  end

  // Stage p1: dispatch strobe, select, pointer and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= '0;
      sel_q       <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= '0;
      if (dispatch) begin
        out_valid_q <= NCH'(1) << idx;
        sel_q       <= idx;
        out_data_q  <= hold_p0;
        ptr_q       <= idx + 1'b1;
        stall_q     <= '0;
      end else if (blocked) begin
        stall_q <= stall_inc(stall_q);
        if (stall_inc(stall_q) >= 8'(STALL_LIM)) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) credit_q[i] <= CW'(CREDITS);
    end else begin
      for (int i = 0; i < NCH; i++)
        credit_q[i] <= credit_next(credit_q[i], bus.credit_ret[i],
                                   dispatch && (idx == SELW'(i)));
    end
  end

  assign bus.in_ready  = !vld_p0;
  assign bus.busy      = vld_p0;
  assign bus.err_stall = err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Scoreboard bench for demux_rr_dispatcher: expected dispatches queued at drive time, checked on strobe.
module tb_demux_rr_dispatcher;

  localparam int DW      = 8;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  demux_rr_dispatcher_if #(.DW(DW)) ifc ();

  demux_rr_dispatcher #(.DW(DW), .CREDITS(CREDITS), .STALL_LIM(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   m_ptr;
  int   m_cred [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference round-robin choice given the bench's own credit/pointer model.
  function automatic int model_pick(input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (en[j] && m_cred[j] > 0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cred[i] = CREDITS;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.credit_ret = '0;
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input int ch);
    int   n;
    exp_t e;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ifc.in_ready) begin
      chk("send_ready", 32'd0, 32'd1);
      return;
    end
    if (ch >= 0) begin
      e.ch = ch;
      e.d  = d;
      sb.push_back(e);
    end
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [DW-1:0] d);
    int ch;
    ch = model_pick(ifc.ch_en);
    if (ch >= 0) begin
      m_cred[ch]--;
      m_ptr = (ch + 1) % 4;
    end
    send(d, ch);
  endtask

  task automatic pulse_ret(input logic [3:0] mask);
    ifc.credit_ret = mask;
    @(posedge clk); #1;
    ifc.credit_ret = '0;
    for (int i = 0; i < 4; i++)
      if (mask[i] && m_cred[i] < CREDITS) m_cred[i]++;
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_dispatch", 32'(ifc.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_valid", 32'(ifc.out_valid), 32'd1 << e.ch);
        chk("out_data", 32'(ifc.out_data), 32'(e.d));
        chk("sel", 32'(ifc.sel), 32'(e.ch));
      end
    end
  end

  initial begin
    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.ch_en      = 4'b1111;
    ifc.credit_ret = '0;
    model_reset();
    #2;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    do_reset();
    chk("rst_out_data", 32'(ifc.out_data), 32'd0);
    chk("rst_sel", 32'(ifc.sel), 32'd0);
    chk("rst_err", 32'(ifc.err_stall), 32'd0);
    chk("rst_ready", 32'(ifc.in_ready), 32'd1);

    // All channels enabled: strict rotation 0,1,2,3,0.
    ifc.ch_en = 4'b1111;
    send_model(8'hA1);
    send_model(8'hB2);
    send_model(8'hC3);
    send_model(8'hD4);
    send_model(8'hE5);
    wait_drain(10);

    // Sparse mask: alternate between ch0 and ch2.
    do_reset();
    ifc.ch_en = 4'b0101;
    send_model(8'h10);
    send_model(8'h20);
    send_model(8'h30);
    send_model(8'h40);
    wait_drain(10);

    // Credit exhaustion on ch0, stall watchdog, recovery by credit return.
    do_reset();
    ifc.ch_en = 4'b0001;
    for (int i = 0; i < 4; i++) send_model(8'(8'h60 + i));
    wait_drain(10);
    send(8'h6F, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_busy", 32'(ifc.busy), 32'd1);
    chk("stall_ready", 32'(ifc.in_ready), 32'd0);
    chk("stall_err_early", 32'(ifc.err_stall), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("stall_err_set", 32'(ifc.err_stall), 32'd1);
    chk("stall_held", sb.size(), 32'd1);
    pulse_ret(4'b0001);
    wait_drain(5);
    chk("stall_err_sticky", 32'(ifc.err_stall), 32'd1);
    chk("stall_idle", 32'(ifc.busy), 32'd0);

    // Return and dispatch on ch1 in the same cycle leave the credit unchanged.
    do_reset();
    ifc.ch_en = 4'b0010;
    send_model(8'h11);
    pulse_ret(4'b0010);
    for (int i = 0; i < 4; i++) send_model(8'(8'h21 + i));
    wait_drain(10);
    send(8'h99, -1);
    repeat (6) @(posedge clk);
    #1;
    chk("samecyc_blocked", 32'(ifc.busy), 32'd1);

    // Excess returns at full credit are ignored.
    do_reset();
    ifc.ch_en = 4'b0010;
    pulse_ret(4'b0010);
    pulse_ret(4'b0010);
    pulse_ret(4'b0010);
    for (int i = 0; i < 4; i++) send_model(8'(8'h31 + i));
    wait_drain(10);
    send(8'h98, -1);
    repeat (6) @(posedge clk);
    #1;
    chk("satret_blocked", 32'(ifc.busy), 32'd1);

    // Mid-stall asynchronous reset discards the held word.
    do_reset();
    ifc.ch_en = 4'b1000;
    send_model(8'h77);
    wait_drain(10);
    chk("pre_sel", 32'(ifc.sel), 32'd3);
    chk("pre_data", 32'(ifc.out_data), 32'h77);
    ifc.ch_en = 4'b0000;
    send(8'h5A, -1);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_err", 32'(ifc.err_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("arst_out_data", 32'(ifc.out_data), 32'd0);
    chk("arst_sel", 32'(ifc.sel), 32'd0);
    chk("arst_busy", 32'(ifc.busy), 32'd0);
    chk("arst_err", 32'(ifc.err_stall), 32'd0);
    chk("arst_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    ifc.ch_en = 4'b1111;
    repeat (10) @(posedge clk);
    #1;
    chk("post_ready", 32'(ifc.in_ready), 32'd1);
    chk("post_busy", 32'(ifc.busy), 32'd0);

    // Enable appears while a word is held: dispatch to ch2, pointer moves to 3.
    do_reset();
    ifc.ch_en = 4'b0000;
    send(8'h3C, 2);
    m_cred[2]--;
    m_ptr = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("toggle_held", 32'(ifc.busy), 32'd1);
    ifc.ch_en = 4'b0100;
    @(posedge clk); #1;
    chk("toggle_strobe", 32'(ifc.out_valid), 32'b0100);
    wait_drain(5);
    ifc.ch_en = 4'b1111;
    send_model(8'h4D);
    wait_drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
